// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// with sign correction and result selection in a final FIX cycle.
// Divide-by-zero and signed overflow bypass the iteration entirely.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiplies).
module ex_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int ITER_CNT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op_A,
  input  logic [XLEN-1:0] op_B,
  input  logic [4:0]      wR_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      res_wR,
  output logic            res_we
);

  localparam int CW = $clog2(ITER_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER_CNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  state_e          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [4:0]      tag_q;
  logic [XLEN-1:0] a_mag_q, b_mag_q;
  logic            neg_q, rneg_q, spec_q;
  logic [XLEN-1:0] spec_res_q;
  logic [XLEN-1:0] mul_hi, mul_lo;
  logic [XLEN-1:0] div_q, div_r;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] spec_res;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] quo_s, rem_s, fix_res;

  // Operand decode: signedness, magnitudes and special-case detection at issue
  always_comb begin
    a_sgn    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_sgn    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_sgn && op_A[XLEN-1];
    b_neg    = b_sgn && op_B[XLEN-1];
    a_mag    = a_neg ? -op_A : op_A;
    b_mag    = b_neg ? -op_B : op_B;
    div_zero = op[2] && (op_B == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
               (op_A == {1'b1, {(XLEN-1){1'b0}}}) && (op_B == '1);
    if (div_zero) spec_res = op[1] ? op_A : '1;
    else          spec_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration step of each datapath, plus final sign correction/selection
  always_comb begin
    mul_sum   = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, a_mag_q} : '0);
    div_shift = {div_r, div_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, b_mag_q};
    prod_s    = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
    quo_s     = neg_q ? -div_q : div_q;
    rem_s     = rneg_q ? -div_r : div_r;
    fix_res   = '0;
    if (spec_q)                  fix_res = spec_res_q;
    else if (op_q[2])            fix_res = op_q[1] ? rem_s : quo_s;
    else if (op_q == OP_MUL)     fix_res = prod_s[XLEN-1:0];
    else                         fix_res = prod_s[2*XLEN-1:XLEN];
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      res_we     <= 1'b0;
      result     <= '0;
      res_wR     <= '0;
      op_q       <= '0;
      tag_q      <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      mul_hi     <= '0;
      mul_lo     <= '0;
      div_q      <= '0;
      div_r      <= '0;
    end else begin
      done   <= 1'b0;
      res_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op_q       <= op;
            tag_q      <= wR_in;
            busy       <= 1'b1;
            cnt        <= '0;
            a_mag_q    <= a_mag;
            b_mag_q    <= b_mag;
            neg_q      <= a_neg ^ b_neg;
            rneg_q     <= a_neg;
            spec_q     <= div_zero || div_ovf;
            spec_res_q <= spec_res;
            mul_hi     <= '0;
            mul_lo     <= b_mag;
            div_q      <= a_mag;
            div_r      <= '0;
            if (div_zero || div_ovf) begin
              state <= S_FIX;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!op[2]) begin
              {mul_hi, mul_lo} <= (2*XLEN)'(a_mag) * (2*XLEN)'(b_mag);
              state            <= S_FIX;
`endif
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            if (op_q[2]) begin
              div_q <= {div_q[XLEN-2:0], div_ge};
              div_r <= div_ge ? XLEN'(div_shift - {1'b0, b_mag_q}) : div_shift[XLEN-1:0];
            end else begin
              mul_hi <= mul_sum[XLEN:1];
              mul_lo <= {mul_sum[0], mul_lo[XLEN-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done   <= 1'b1;
            result <= fix_res;
            res_wR <= tag_q;
            res_we <= (tag_q != 5'd0);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
